// File: rtl/rgb_to_luma_if.sv
// Pixel-stream bundle between the RGB source and the luma stage: colour/sync in, luma/sync/geometry out.
// Timing and backpressure are set by rgb_to_luma (fixed 3 cycles, never stalls).
interface rgb_to_luma_if;
   logic [7:0]  r_i;
   logic [7:0]  g_i;
   logic [7:0]  b_i;
   logic        dv_i;
   logic        hs_i;
   logic        vs_i;
   logic [7:0]  y_o;
   logic        dv_o;
   logic        hs_o;
   logic        vs_o;
   logic [10:0] cols_o;
   logic [9:0]  rows_o;
   logic        geom_err_o;

   modport master (
      output r_i, g_i, b_i, dv_i, hs_i, vs_i,
      input  y_o, dv_o, hs_o, vs_o, cols_o, rows_o, geom_err_o
   );

   modport slave (
      input  r_i, g_i, b_i, dv_i, hs_i, vs_i,
      output y_o, dv_o, hs_o, vs_o, cols_o, rows_o, geom_err_o
   );
endinterface

// File: rtl/rgb_to_luma.sv
// RGB888 -> 8-bit luma with syncs delayed to match, plus frame-geometry monitor.
// Latency 3 cycles, 1 pixel/clk, no backpressure (never stalls).
module rgb_to_luma #(
   parameter int ACT_COLS = 1600,
   parameter int ACT_ROWS = 900
) (
   input logic          clk,
   input logic          rst,
   rgb_to_luma_if.slave bus
);
   typedef enum logic {UNSYNC, SYNC} state_t;

   state_t      state, state_nxt;
   logic [15:0] prod_r, prod_g, prod_b;
   logic [16:0] sum;
   logic [2:0]  dv_d, hs_d, vs_d;
   logic        hs_prev, vs_prev;
   logic        hs_rise, vs_rise;
   logic [10:0] pix_cnt, pix_inc;
   logic [9:0]  line_cnt, line_cnt_nxt;
   logic        line_bad, line_bad_nxt;
   logic        line_close;

   assign hs_rise = bus.hs_i & ~hs_prev;
   assign vs_rise = bus.vs_i & ~vs_prev;

   assign bus.dv_o = dv_d[2];
   assign bus.hs_o = hs_d[2];
   assign bus.vs_o = vs_d[2];

   // A line closes on hs rise, or on vs rise if still pending; this cycle's pixel counts first.
   always_comb begin
      state_nxt    = state;
      line_cnt_nxt = line_cnt;
      line_bad_nxt = line_bad;
      pix_inc      = (bus.dv_i && pix_cnt != 11'h7FF) ? pix_cnt + 11'd1 : pix_cnt;
      line_close   = (hs_rise | vs_rise) && (pix_inc != 11'd0);
      if (line_close) begin
         if (line_cnt != 10'h3FF)
            line_cnt_nxt = line_cnt + 10'd1;
         if (pix_inc != 11'(ACT_COLS))
            line_bad_nxt = 1'b1;
      end
      if (vs_rise && state == UNSYNC)
         state_nxt = SYNC;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= UNSYNC;
         prod_r         <= '0;
         prod_g         <= '0;
         prod_b         <= '0;
         sum            <= '0;
         dv_d           <= '0;
         hs_d           <= '0;
         vs_d           <= '0;
         bus.y_o        <= '0;
         hs_prev        <= 1'b0;
         vs_prev        <= 1'b0;
         pix_cnt        <= '0;
         line_cnt       <= '0;
         line_bad       <= 1'b0;
         bus.cols_o     <= '0;
         bus.rows_o     <= '0;
         bus.geom_err_o <= 1'b0;
      end else begin
         state   <= state_nxt;
         prod_r  <= 16'(bus.r_i) * 16'd77;
         prod_g  <= 16'(bus.g_i) * 16'd150;
         prod_b  <= 16'(bus.b_i) * 16'd29;
         sum     <= 17'(prod_r) + 17'(prod_g) + 17'(prod_b) + 17'd128;
         dv_d    <= {dv_d[1:0], bus.dv_i};
         hs_d    <= {hs_d[1:0], bus.hs_i};
         vs_d    <= {vs_d[1:0], bus.vs_i};
         bus.y_o <= dv_d[1] ? 8'(sum >> 8) : 8'd0;
         hs_prev <= bus.hs_i;
         vs_prev <= bus.vs_i;
         pix_cnt <= (hs_rise | vs_rise) ? 11'd0 : pix_inc;
         if (line_close)
            bus.cols_o <= pix_inc;
         if (vs_rise) begin
            line_cnt <= '0;
            line_bad <= 1'b0;
            // The frame before the first vs was seen only partially, so it is not reported.
            if (state == SYNC) begin
               bus.rows_o     <= line_cnt_nxt;
               bus.geom_err_o <= (line_cnt_nxt != 10'(ACT_ROWS)) | line_bad_nxt;
            end
         end else begin
            line_cnt <= line_cnt_nxt;
            line_bad <= line_bad_nxt;
         end
      end
   end
endmodule
